// File: rtl/gaussian_conv_if.sv
// Window hand-off from conv_memory/pixel_pos plus the output image SRAM write port.
// The slave side is the convolution engine; the master side is whatever feeds
// windows and owns the output SRAM.
interface gaussian_conv_if #(
    parameter int MAX_KERNAL  = 9,
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16
);
    logic                                         new_sample_ready;
    logic [MAX_KERNAL*MAX_KERNAL*PIXEL_DEPTH-1:0] working_memory;
    logic [$clog2(X_MAX)-1:0]                     curr_x;
    logic [$clog2(Y_MAX)-1:0]                     curr_y;
    logic                                         end_pos;
    logic                                         new_sample_req;
    logic                                         wen_out;
    logic [$clog2(X_MAX):0]                       x_addr_out;
    logic [$clog2(Y_MAX):0]                       y_addr_out;
    logic [PIXEL_DEPTH-1:0]                       wdat_out;

    modport master (
        output new_sample_ready, working_memory, curr_x, curr_y, end_pos,
        input  new_sample_req, wen_out, x_addr_out, y_addr_out, wdat_out
    );

    modport slave (
        input  new_sample_ready, working_memory, curr_x, curr_y, end_pos,
        output new_sample_req, wen_out, x_addr_out, y_addr_out, wdat_out
    );
endinterface

// File: rtl/gaussian_conv.sv
// Sequential kernel convolution: captures one window, multiply-accumulates it
// against a programmable coefficient table one tap per cycle, then rounds,
// normalises, saturates and writes a single output pixel.
// Window layout: pixel (x, y) lives at bits [((x*MAX_KERNAL)+y)*PIXEL_DEPTH +: PIXEL_DEPTH].
module gaussian_conv #(
    parameter int MAX_KERNAL  = 9,
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    parameter int WEIGHT_W    = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      new_trans,
    input  logic [7:0]                                kernel_size,
    input  logic [4:0]                                norm_shift,
    input  logic                                      coef_wen,
    input  logic [$clog2(MAX_KERNAL*MAX_KERNAL)-1:0]  coef_idx,
    input  logic [WEIGHT_W-1:0]                       coef_wdat,
    gaussian_conv_if.slave                            win_bus,
    output logic                                      busy,
    output logic                                      done
);
    localparam int TAPS    = MAX_KERNAL * MAX_KERNAL;
    localparam int CI_W    = $clog2(TAPS);
    localparam int T_W     = $clog2(MAX_KERNAL);
    localparam int K_W     = $clog2(MAX_KERNAL + 1);
    localparam int XW      = $clog2(X_MAX);
    localparam int YW      = $clog2(Y_MAX);
    localparam int PROD_W  = PIXEL_DEPTH + WEIGHT_W;
    localparam int ACC_W   = PIXEL_DEPTH + WEIGHT_W + $clog2(TAPS) + 1;
    // Rounding constant can reach 2^30 for the largest shift, so the rounding
    // adder is kept wider than both the accumulator and that constant.
    localparam int RND_W   = ((ACC_W > 32) ? ACC_W : 32) + 1;
    localparam int PIX_MAX = (1 << PIXEL_DEPTH) - 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, MAC, WRITE, REQ, DRAIN, DONE
    } state_t;

    state_t state, next_state;

    logic [WEIGHT_W-1:0]    coef  [TAPS];
    logic [PIXEL_DEPTH-1:0] win_q [MAX_KERNAL][MAX_KERNAL];

    logic [K_W-1:0]         k_eff;
    logic [K_W-1:0]         k_clamped;
    logic [T_W-1:0]         tx;
    logic [T_W-1:0]         ty;
    logic [ACC_W-1:0]       acc;
    logic [XW-1:0]          cap_x;
    logic [YW-1:0]          cap_y;
    logic                   cap_end;
    logic [XW:0]            x_addr_q;
    logic [YW:0]            y_addr_q;
    logic [PIXEL_DEPTH-1:0] wdat_q;

    logic                   capture;
    logic                   mac_step;
    logic                   row_end;
    logic                   mac_last;
    logic [CI_W-1:0]        tap_idx;
    logic [PROD_W-1:0]      prod;
    logic [ACC_W-1:0]       acc_next;
    logic [RND_W-1:0]       rnd;
    logic [RND_W-1:0]       rounded;
    logic [PIXEL_DEPTH-1:0] sat_pix;

    // Clamp the requested kernel edge into 1..MAX_KERNAL
    always_comb begin
        if (kernel_size == 8'd0)
            k_clamped = K_W'(1);
        else if (kernel_size > 8'(MAX_KERNAL))
            k_clamped = K_W'(MAX_KERNAL);
        else
            k_clamped = kernel_size[K_W-1:0];
    end

    // Tap arithmetic: current product, next accumulator and the rounded, saturated pixel
    always_comb begin
        capture  = (state == WAIT_RDY) && win_bus.new_sample_ready && !new_trans;
        mac_step = (state == MAC) && !new_trans;
        row_end  = (K_W'(tx) == k_eff - K_W'(1));
        mac_last = (state == MAC) && row_end && (K_W'(ty) == k_eff - K_W'(1));
        tap_idx  = CI_W'(int'(ty) * MAX_KERNAL + int'(tx));
        prod     = PROD_W'(win_q[tx][ty]) * PROD_W'(coef[tap_idx]);
        acc_next = acc + ACC_W'(prod);
        rnd      = (norm_shift == 5'd0) ? '0 : (RND_W'(1) << (norm_shift - 5'd1));
        rounded  = (RND_W'(acc_next) + rnd) >> norm_shift;
        sat_pix  = (rounded > RND_W'(PIX_MAX)) ? '1 : rounded[PIXEL_DEPTH-1:0];
    end

    // Coefficient table is only writable while the engine is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++)
                coef[i] <= '0;
        end else if ((state == IDLE) && coef_wen && (coef_idx < CI_W'(TAPS))) begin
            coef[coef_idx] <= coef_wdat;
        end
    end

    // Snapshot the whole window so upstream may move on while we accumulate
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int x = 0; x < MAX_KERNAL; x++)
                for (int y = 0; y < MAX_KERNAL; y++)
                    win_q[x][y] <= win_bus.working_memory[((x * MAX_KERNAL) + y) * PIXEL_DEPTH +: PIXEL_DEPTH];
        end
    end

    // Datapath registers: kernel size, capture context, accumulator, tap counters, output pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            k_eff    <= K_W'(1);
            tx       <= '0;
            ty       <= '0;
            acc      <= '0;
            cap_x    <= '0;
            cap_y    <= '0;
            cap_end  <= 1'b0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            wdat_q   <= '0;
        end else begin
            if (new_trans)
                k_eff <= k_clamped;
            if (capture) begin
                cap_x   <= win_bus.curr_x;
                cap_y   <= win_bus.curr_y;
                cap_end <= win_bus.end_pos;
                acc     <= '0;
                tx      <= '0;
                ty      <= '0;
            end
            if (mac_step) begin
                acc <= acc_next;
                if (row_end) begin
                    tx <= '0;
                    ty <= ty + T_W'(1);
                end else begin
                    tx <= tx + T_W'(1);
                end
                if (mac_last) begin
                    x_addr_q <= {1'b0, cap_x};
                    y_addr_q <= {1'b0, cap_y};
                    wdat_q   <= sat_pix;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; new_trans restarts from any state
    always_comb begin
        next_state = state;
        if (new_trans) begin
            next_state = WAIT_RDY;
        end else begin
            case (state)
                IDLE:     next_state = IDLE;
                WAIT_RDY: if (win_bus.new_sample_ready) next_state = MAC;
                MAC:      if (mac_last) next_state = WRITE;
                WRITE:    next_state = cap_end ? DONE : REQ;
                REQ:      next_state = DRAIN;
                DRAIN:    if (!win_bus.new_sample_ready) next_state = WAIT_RDY;
                DONE:     next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    // Strobes are suppressed on a cycle that is being reset or aborted
    always_comb begin
        win_bus.wen_out        = (state == WRITE) && !rst && !new_trans;
        win_bus.new_sample_req = (state == REQ) && !rst && !new_trans;
        done                   = (state == DONE) && !rst;
        busy                   = (state != IDLE);
    end

    assign win_bus.x_addr_out = x_addr_q;
    assign win_bus.y_addr_out = y_addr_q;
    assign win_bus.wdat_out   = wdat_q;
endmodule

// File: doc/gaussian_conv.md
Name: gaussian_conv

Overview:
Downstream consumer of conv_memory. Takes the kernel window (working_memory) when new_sample_ready is high, and runs a sequential multiply-accumulate against a programmable coefficient table, one tap per cycle. It then normalises and saturates the sum, writes one output pixel to the output image SRAM at the captured (curr_x, curr_y), and pulses new_sample_req to advance pixel_pos and conv_memory.

Parameters:
MAX_KERNAL, 9, max kernel edge; working_memory is MAX_KERNAL x MAX_KERNAL
PIXEL_DEPTH, 8, bits per pixel
X_MAX, 16, max image width
Y_MAX, 16, max image height
WEIGHT_W, 8, unsigned coefficient width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
new_trans  in  1  pulse: start or restart a frame
kernel_size  in  8  active kernel edge k; 0 is treated as 1; values >MAX_KERNAL are treated as MAX_KERNAL
norm_shift  in  5  right shift applied to the accumulator
coef_wen  in  1  coefficient write strobe
coef_idx  in  $clog2(MAX_KERNAL*MAX_KERNAL)  index = y*MAX_KERNAL + x
coef_wdat  in  WEIGHT_W  coefficient value
new_sample_ready  in  1  window valid (from conv_memory)
working_memory  in  MAX_KERNAL*MAX_KERNAL*PIXEL_DEPTH  window, indexed [x][y]
curr_x  in  $clog2(X_MAX)  window centre x (from pixel_pos)
curr_y  in  $clog2(Y_MAX)  window centre y
end_pos  in  1  current position is the last pixel of the frame
new_sample_req  out  1  one-cycle pulse: request next window
wen_out  out  1  output SRAM write enable
x_addr_out  out  $clog2(X_MAX)+1  output write x
y_addr_out  out  $clog2(Y_MAX)+1  output write y
wdat_out  out  PIXEL_DEPTH  output pixel
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all outputs 0; accumulator and counters 0.
  - Coefficient table resets to all 0.
- Coefficient table: MAX_KERNAL^2 x WEIGHT_W registers. coef_wen writes on the clock edge only while state=IDLE; writes are ignored otherwise.
- k_eff = clamped kernel_size, latched on new_trans.
- FSM states: IDLE, WAIT_RDY, MAC, WRITE, REQ, DRAIN, DONE.
- IDLE: new_trans -> WAIT_RDY.
- WAIT_RDY: on new_sample_ready=1:
  - capture curr_x, curr_y, end_pos and the full working_memory;
  - clear acc and tap counters tx=ty=0;
  - -> MAC.
- MAC: each cycle acc += win[tx][ty] * coef[ty*MAX_KERNAL+tx].
  - tx increments; it wraps to 0 at k_eff-1, and ty increments on that wrap.
  - After tap (k_eff-1, k_eff-1) -> WRITE.
  - MAC takes exactly k_eff^2 cycles.
- WRITE: one cycle with wen_out=1, addresses = captured x/y, and wdat_out = sat((acc + rnd) >> norm_shift).
  - rnd = 1<<(norm_shift-1) when norm_shift>0, else 0.
  - sat clamps to 2^PIXEL_DEPTH-1.
  - Next state: DONE if the captured end_pos=1, else REQ.
- REQ: new_sample_req=1 for exactly one cycle -> DRAIN.
- DRAIN: wait until new_sample_ready=0 -> WAIT_RDY. This prevents reusing a stale window.
- DONE: done=1 for one cycle -> IDLE.
- Latency: from the capture cycle in WAIT_RDY, wen_out asserts k_eff^2+1 cycles later. new_sample_req follows 1 cycle after wen_out.
- Arithmetic widths:
  - acc width = PIXEL_DEPTH+WEIGHT_W+$clog2(MAX_KERNAL^2)+1; no overflow is possible.
  - Products and acc are unsigned.
- Outputs outside WRITE: wen_out=0; wdat_out and addresses hold their last value.
- new_trans in any non-IDLE state aborts the current pixel with no write and no req. The block re-latches k_eff and goes to WAIT_RDY.
- rst has priority over new_trans.
- rst mid-operation returns to IDLE immediately; nothing is written on that cycle.
- new_sample_ready is ignored outside WAIT_RDY and DRAIN.

Test Plan:
- k=1, coef[0]=1, norm_shift=0, win[0][0]=0x37, ready high: wen_out exactly 2 cycles after capture, wdat_out=0x37, addr=(curr_x,curr_y); new_sample_req pulses the next cycle.
- k=3, all 9 coefs=1, shift=3, all pixels 8: acc=72, wdat_out=(72+4)>>3=9; MAC lasts 9 cycles.
- k=3, Gaussian coefs 1,2,1/2,4,2/1,2,1, shift=4, centre 160 and others 0: wdat_out=(640+8)>>4=40. With all pixels 200: wdat_out=200.
- k=9, all coefs 255, all pixels 255, shift=0: wdat_out saturates to 255.
- 5x5 frame with end_pos high on the 25th window: 25 wen_out pulses and 24 new_sample_req pulses, then done for one cycle, then busy=0.
- Negative cases:
  - new_trans asserted mid-MAC produces no wen_out and returns to WAIT_RDY.
  - rst mid-MAC drives all outputs to 0 on the next edge.
  - coef_wen while busy leaves the table unchanged.
